// File: rtl/pe_operand_seq.sv
// Operand sequencer: fills DEPTH slots from a stream, then walks a select
// over those slots (rep_num+1) times so a downstream mux can issue them.
module pe_operand_seq #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int SEL_WIDTH = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [3:0]                      rep_num,
  output logic [DEPTH-1:0][WIDTH-1:0]     buf_data,
  output logic [SEL_WIDTH-1:0]            sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done,
  output logic                            busy
);

  typedef enum logic {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(DEPTH - 1);
  localparam logic [SEL_WIDTH-1:0] ONE  = SEL_WIDTH'(1);

  state_t                        state_q;
  logic [SEL_WIDTH-1:0]          wr_ptr_q;
  logic [SEL_WIDTH-1:0]          sel_q;
  logic [3:0]                    pass_q;
  logic [DEPTH-1:0][WIDTH-1:0]   buf_q;

  logic in_hs;
  logic out_hs;
  logic wrap;

  assign in_hs  = (state_q == LOAD) & in_valid & ~flush;
  assign out_hs = (state_q == ISSUE) & out_ready;
  assign wrap   = out_hs & (sel_q == LAST);

  assign in_ready  = (state_q == LOAD) & ~flush;
  assign out_valid = (state_q == ISSUE);
  assign busy      = (state_q == ISSUE);
  // Final handshake of the last pass; an abort in the same cycle cancels it.
  assign done      = wrap & (pass_q == 4'd0) & ~flush;
  assign buf_data  = buf_q;
  assign sel       = sel_q;

  // Sequencer state, pointers and operand slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      sel_q    <= '0;
      pass_q   <= 4'd0;
      buf_q    <= '0;
    end else if (flush) begin
      // Abort keeps slot contents so a later reload can overwrite selectively.
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      sel_q    <= '0;
      pass_q   <= 4'd0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_hs) begin
            buf_q[wr_ptr_q] <= in_data;
            if (wr_ptr_q == LAST) begin
              wr_ptr_q <= '0;
              sel_q    <= '0;
              pass_q   <= rep_num;
              state_q  <= ISSUE;
            end else begin
              wr_ptr_q <= wr_ptr_q + ONE;
            end
          end
        end
        ISSUE: begin
          if (out_hs) begin
            if (sel_q == LAST) begin
              sel_q <= '0;
              if (pass_q != 4'd0) begin
                pass_q <= pass_q - 4'd1;
              end else begin
                state_q <= LOAD;
              end
            end else begin
              sel_q <= sel_q + ONE;
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_operand_seq.sv
// Directed self-checking bench for pe_operand_seq (WIDTH=8, DEPTH=8).
module tb_pe_operand_seq;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic [3:0]      rep_num;
  logic [7:0][7:0] buf_data;
  logic [2:0]      sel;
  logic            out_valid;
  logic            out_ready;
  logic            done;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  pe_operand_seq #(.WIDTH(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rep_num   (rep_num),
    .buf_data  (buf_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the 8th write.
  task automatic load8(input logic [7:0] base, input logic [3:0] rep);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      rep_num  = rep;
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_out_valid", out_valid, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rep_num  = 4'd9;
    #1;
    check("first_out_valid", out_valid, 1);
    check("first_sel", sel, 0);
  endtask

  task automatic drain8();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("drain_sel", sel, k);
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check("drain_idle", out_valid, 0);
  endtask

  initial begin
    int hs;
    int dones;
    int exp_sel;
    int done_cyc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    rep_num = 4'd0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", sel, 0);
    check("rst_buf", buf_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single pass over 0x10..0x17
    load8(8'h10, 4'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t1_sel", sel, k);
      check("t1_valid", out_valid, 1);
      check("t1_busy", busy, 1);
      check("t1_data", buf_data[sel], 32'h10 + k);
      check("t1_done", done, (k == 7) ? 1 : 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    check("t1_in_ready_after", in_ready, 1);
    check("t1_busy_after", busy, 0);

    // Three passes with a single done
    load8(8'h10, 4'd2);
    out_ready = 1'b1;
    hs = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) #1;
      if (!out_valid) break;
      check("t2_sel", sel, hs % 8);
      check("t2_data", buf_data[sel], 32'h10 + (hs % 8));
      if (done) begin
        dones++;
        check("t2_done_at", hs, 23);
      end
      hs++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("t2_handshakes", hs, 24);
    check("t2_done_count", dones, 1);

    // Backpressure: ready toggles 0/1
    @(negedge clk);
    load8(8'h20, 4'd0);
    exp_sel = 0; done_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 1);
      #1;
      check("t3_valid", out_valid, 1);
      check("t3_sel", sel, exp_sel);
      if (done) done_cyc = c;
      if (out_ready) exp_sel = (exp_sel + 1) % 8;
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    out_ready = 1'b0;
    check("t3_done_cycle", done_cyc, 15);

    // Flush during load with in_valid high
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
    #1;
    check("t4_in_ready_flush", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    load8(8'h40, 4'd0);
    for (int i = 0; i < 8; i++) check("t4_slot", buf_data[i], 32'h40 + i);
    drain8();

    // Asynchronous reset mid-issue at sel 4
    @(negedge clk);
    load8(8'h50, 4'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("t5_sel_before", sel, 4);
    #1;
    rst = 1'b1;
    #1;
    check("t5_sel", sel, 0);
    check("t5_valid", out_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_buf", buf_data, 64'h0);
    check("t5_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("t5_done_hold", done, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;

    // Flush on the final issue handshake
    load8(8'h60, 4'd0);
    out_ready = 1'b1;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    #1;
    check("t6_sel", sel, 7);
    check("t6_done", done, 0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_sel_after", sel, 0);
    for (int i = 0; i < 8; i++) check("t6_slot", buf_data[i], 32'h60 + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
